// File: rtl/uart_receive.sv
// Purpose: 8N1 serial receiver that parses "D.DDD" CR LF lines into four BCD digits.
// Latency: rx_byte_valid about 9.5 bit times plus SYNC_STAGES cycles after the start edge; data_ready one cycle after the LF byte.
// Backpressure: none; every strobe is a single-cycle pulse that the consumer must catch.
module uart_receive #(
  parameter int OS_RATE     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       baud_clk,
  input  logic       reset_n,
  input  logic       pc_serial_data_in,
  output logic [3:0] thousands,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       data_ready,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic       frame_error,
  output logic       parse_error
);

  localparam int OS_W = (OS_RATE > 1) ? $clog2(OS_RATE) : 1;
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OS_RATE - 1);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OS_RATE / 2 - 1);
  localparam logic [OS_W-1:0] OS_ONE  = OS_W'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} bit_state_t;

  bit_state_t       state, state_nxt;
  logic [OS_W-1:0]  os_cnt, os_cnt_nxt;
  logic [2:0]       bit_cnt, bit_cnt_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic             byte_done;
  logic             byte_bad;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;

  logic [2:0] idx;
  logic [3:0] held_thousands, held_hundreds, held_tens, held_ones;
  logic       is_digit;
  logic       char_ok;

  // Synchronize the asynchronous line; resets to idle-high so no false start is seen.
  always_ff @(posedge baud_clk) begin
    if (!reset_n) sync_q <= '1;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], pc_serial_data_in};
  end

  assign rxs = sync_q[SYNC_STAGES-1];

  // Bit FSM state and counters.
  always_ff @(posedge baud_clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      os_cnt  <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nxt;
      os_cnt  <= os_cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
    end
  end

  // Bit FSM next state: half a bit into START to find mid-bit, then whole bits per sample.
  always_comb begin
    state_nxt   = state;
    os_cnt_nxt  = os_cnt + OS_ONE;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    byte_done   = 1'b0;
    byte_bad    = 1'b0;
    case (state)
      IDLE: begin
        os_cnt_nxt = '0;
        if (!rxs) state_nxt = START;
      end
      START: begin
        if (os_cnt == OS_MID) begin
          os_cnt_nxt  = '0;
          bit_cnt_nxt = '0;
          // A line that is high again at mid-bit was only a glitch.
          state_nxt   = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (os_cnt == OS_LAST) begin
          os_cnt_nxt  = '0;
          shreg_nxt   = {rxs, shreg[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (os_cnt == OS_LAST) begin
          os_cnt_nxt = '0;
          state_nxt  = IDLE;
          byte_done  = rxs;
          byte_bad   = !rxs;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Register the received byte and the byte-level strobes.
  always_ff @(posedge baud_clk) begin
    if (!reset_n) begin
      rx_byte       <= '0;
      rx_byte_valid <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      rx_byte_valid <= byte_done;
      frame_error   <= byte_bad;
      if (byte_done) rx_byte <= shreg;
    end
  end

  // Decide whether the current byte is the character expected at this line position.
  always_comb begin
    is_digit = (rx_byte[7:4] == 4'h3) && (rx_byte[3:0] <= 4'd9);
    char_ok  = 1'b0;
    case (idx)
      3'd0, 3'd2, 3'd3, 3'd4: char_ok = is_digit;
      3'd1:                   char_ok = (rx_byte == 8'h2E);
      3'd5:                   char_ok = (rx_byte == 8'h0D);
      3'd6:                   char_ok = (rx_byte == 8'h0A);
      default:                char_ok = 1'b0;
    endcase
  end

  // Line parser: digits are staged in held_* and only published when the full line checks out.
  always_ff @(posedge baud_clk) begin
    if (!reset_n) begin
      idx            <= '0;
      held_thousands <= '0;
      held_hundreds  <= '0;
      held_tens      <= '0;
      held_ones      <= '0;
      thousands      <= '0;
      hundreds       <= '0;
      tens           <= '0;
      ones           <= '0;
      data_ready     <= 1'b0;
      parse_error    <= 1'b0;
    end else begin
      data_ready  <= 1'b0;
      parse_error <= 1'b0;
      if (rx_byte_valid) begin
        if (char_ok) begin
          case (idx)
            3'd0:    held_thousands <= rx_byte[3:0];
            3'd2:    held_hundreds  <= rx_byte[3:0];
            3'd3:    held_tens      <= rx_byte[3:0];
            3'd4:    held_ones      <= rx_byte[3:0];
            default: ;
          endcase
          if (idx == 3'd6) begin
            thousands  <= held_thousands;
            hundreds   <= held_hundreds;
            tens       <= held_tens;
            ones       <= held_ones;
            data_ready <= 1'b1;
            idx        <= '0;
          end else begin
            idx <= idx + 3'd1;
          end
        end else begin
          // The offending byte is dropped rather than retried as a first character.
          parse_error <= 1'b1;
          idx         <= '0;
        end
      end else if (frame_error) begin
        idx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receive.sv
// Bench for uart_receive: drives 8N1 frames at 16 cycles per bit and checks
// received bytes, parsed lines and error strobes against queued expectations.
module tb_uart_receive;

  localparam int OS = 16;

  logic       baud_clk = 1'b0;
  logic       reset_n;
  logic       rx_line;
  logic [3:0] thousands, hundreds, tens, ones;
  logic       data_ready;
  logic [7:0] rx_byte;
  logic       rx_byte_valid, frame_error, parse_error;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  exp_bytes[$];
  logic [7:0]  obs_bytes[$];
  logic [15:0] exp_lines[$];
  logic [15:0] obs_lines[$];

  int fe_cnt = 0, pe_cnt = 0, wide_cnt = 0, clash_cnt = 0;
  int fe_base = 0, pe_base = 0;
  logic prev_rbv = 1'b0, prev_dr = 1'b0, prev_fe = 1'b0, prev_pe = 1'b0;

  uart_receive #(.OS_RATE(OS), .SYNC_STAGES(2)) dut (
    .baud_clk          (baud_clk),
    .reset_n           (reset_n),
    .pc_serial_data_in (rx_line),
    .thousands         (thousands),
    .hundreds          (hundreds),
    .tens              (tens),
    .ones              (ones),
    .data_ready        (data_ready),
    .rx_byte           (rx_byte),
    .rx_byte_valid     (rx_byte_valid),
    .frame_error       (frame_error),
    .parse_error       (parse_error)
  );

  always #5 baud_clk = ~baud_clk;

  // Record every output event away from the active edge.
  always @(negedge baud_clk) begin
    if (rx_byte_valid === 1'b1) obs_bytes.push_back(rx_byte);
    if (data_ready === 1'b1)    obs_lines.push_back({thousands, hundreds, tens, ones});
    if (frame_error === 1'b1)   fe_cnt++;
    if (parse_error === 1'b1)   pe_cnt++;
    if ((rx_byte_valid === 1'b1 && prev_rbv) || (data_ready === 1'b1 && prev_dr) ||
        (frame_error === 1'b1 && prev_fe) || (parse_error === 1'b1 && prev_pe))
      wide_cnt++;
    if (data_ready === 1'b1 && parse_error === 1'b1) clash_cnt++;
    prev_rbv = (rx_byte_valid === 1'b1);
    prev_dr  = (data_ready === 1'b1);
    prev_fe  = (frame_error === 1'b1);
    prev_pe  = (parse_error === 1'b1);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic idle(input int n);
    rx_line = 1'b1;
    repeat (n) @(negedge baud_clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx_line = 1'b0;
    repeat (OS) @(negedge baud_clk);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      repeat (OS) @(negedge baud_clk);
    end
    rx_line = stop_bit;
    repeat (OS) @(negedge baud_clk);
    rx_line = 1'b1;
  endtask

  task automatic send_line(input string s);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i], 1'b1);
      exp_bytes.push_back(s[i]);
    end
    send_byte(8'h0D, 1'b1);
    exp_bytes.push_back(8'h0D);
    send_byte(8'h0A, 1'b1);
    exp_bytes.push_back(8'h0A);
  endtask

  task automatic start_test();
    exp_bytes.delete();
    obs_bytes.delete();
    exp_lines.delete();
    obs_lines.delete();
    fe_base = fe_cnt;
    pe_base = pe_cnt;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    @(negedge baud_clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    rx_line = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(negedge baud_clk);
    n_checks++;
    if ({thousands, hundreds, tens, ones} !== 16'h0000) begin
      n_fail++; $display("FAIL reset_digits: got %h want 0000", {thousands, hundreds, tens, ones});
    end
    n_checks++;
    if (rx_byte !== 8'h00) begin
      n_fail++; $display("FAIL reset_rx_byte: got %h want 00", rx_byte);
    end
    n_checks++;
    if ({data_ready, rx_byte_valid, frame_error, parse_error} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_pulses: got %b want 0000", {data_ready, rx_byte_valid, frame_error, parse_error});
    end
    reset_n = 1'b1;
    idle(5);
  endtask

  task automatic test_single_byte();
    start_test();
    send_byte(8'h35, 1'b1);
    exp_bytes.push_back(8'h35);
    idle(4);
    n_checks++;
    if (obs_bytes.size() != exp_bytes.size()) begin
      n_fail++; $display("FAIL single_count: got %0d want %0d", obs_bytes.size(), exp_bytes.size());
    end
    while (obs_bytes.size() > 0 && exp_bytes.size() > 0) begin
      logic [7:0] e, o;
      e = exp_bytes.pop_front();
      o = obs_bytes.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++; $display("FAIL single_byte: got %h want %h", o, e);
      end
    end
    n_checks++;
    if ((fe_cnt - fe_base) != 0 || (pe_cnt - pe_base) != 0) begin
      n_fail++; $display("FAIL single_errors: got fe=%0d pe=%0d want 0 0", fe_cnt - fe_base, pe_cnt - pe_base);
    end
    pulse_reset();
    idle(4);
  endtask

  task automatic test_full_line();
    start_test();
    send_line("3.141");
    exp_lines.push_back(16'h3141);
    idle(4);
    n_checks++;
    if (obs_bytes.size() != 7) begin
      n_fail++; $display("FAIL line_byte_count: got %0d want 7", obs_bytes.size());
    end
    while (obs_bytes.size() > 0 && exp_bytes.size() > 0) begin
      logic [7:0] e, o;
      e = exp_bytes.pop_front();
      o = obs_bytes.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++; $display("FAIL line_byte: got %h want %h", o, e);
      end
    end
    n_checks++;
    if (obs_lines.size() != exp_lines.size()) begin
      n_fail++; $display("FAIL line_count: got %0d want %0d", obs_lines.size(), exp_lines.size());
    end
    while (obs_lines.size() > 0 && exp_lines.size() > 0) begin
      logic [15:0] e, o;
      e = exp_lines.pop_front();
      o = obs_lines.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++; $display("FAIL line_digits: got %h want %h", o, e);
      end
    end
    n_checks++;
    if ((fe_cnt - fe_base) != 0 || (pe_cnt - pe_base) != 0) begin
      n_fail++; $display("FAIL line_errors: got fe=%0d pe=%0d want 0 0", fe_cnt - fe_base, pe_cnt - pe_base);
    end
  endtask

  task automatic test_frame_error();
    start_test();
    send_byte(8'h41, 1'b0);
    idle(20);
    n_checks++;
    if ((fe_cnt - fe_base) != 1) begin
      n_fail++; $display("FAIL frame_pulse: got %0d want 1", fe_cnt - fe_base);
    end
    n_checks++;
    if (obs_bytes.size() != 0) begin
      n_fail++; $display("FAIL frame_no_valid: got %0d bytes want 0", obs_bytes.size());
    end
    n_checks++;
    if (rx_byte !== 8'h0A) begin
      n_fail++; $display("FAIL frame_rx_hold: got %h want 0a", rx_byte);
    end
    n_checks++;
    if ((pe_cnt - pe_base) != 0) begin
      n_fail++; $display("FAIL frame_no_parse: got %0d want 0", pe_cnt - pe_base);
    end
    start_test();
    send_line("1.000");
    idle(4);
    n_checks++;
    if (obs_lines.size() != 1 || obs_lines[0] !== 16'h1000) begin
      n_fail++; $display("FAIL frame_recovery: got %0d lines, first %h want 1 line 1000",
                         obs_lines.size(), (obs_lines.size() > 0) ? obs_lines[0] : 16'hxxxx);
    end
  endtask

  task automatic test_parse_error();
    start_test();
    // ',' fails at index 1; the rest then re-syncs and fails three more times.
    send_line("2,500");
    idle(4);
    n_checks++;
    if ((pe_cnt - pe_base) != 4) begin
      n_fail++; $display("FAIL parse_pulses: got %0d want 4", pe_cnt - pe_base);
    end
    n_checks++;
    if (obs_lines.size() != 0) begin
      n_fail++; $display("FAIL parse_no_ready: got %0d lines want 0", obs_lines.size());
    end
    n_checks++;
    if ({thousands, hundreds, tens, ones} !== 16'h1000) begin
      n_fail++; $display("FAIL parse_hold: got %h want 1000", {thousands, hundreds, tens, ones});
    end
    start_test();
    send_line("7.250");
    idle(4);
    n_checks++;
    if (obs_lines.size() != 1 || obs_lines[0] !== 16'h7250) begin
      n_fail++; $display("FAIL parse_recovery: got %0d lines, first %h want 1 line 7250",
                         obs_lines.size(), (obs_lines.size() > 0) ? obs_lines[0] : 16'hxxxx);
    end
    n_checks++;
    if ((pe_cnt - pe_base) != 0) begin
      n_fail++; $display("FAIL parse_recovery_clean: got %0d want 0", pe_cnt - pe_base);
    end
  endtask

  task automatic test_glitch();
    start_test();
    rx_line = 1'b0;
    repeat (4) @(negedge baud_clk);
    idle(40);
    n_checks++;
    if (obs_bytes.size() != 0 || (fe_cnt - fe_base) != 0 || (pe_cnt - pe_base) != 0) begin
      n_fail++; $display("FAIL glitch_quiet: got bytes=%0d fe=%0d pe=%0d want 0 0 0",
                         obs_bytes.size(), fe_cnt - fe_base, pe_cnt - pe_base);
    end
    send_byte(8'h36, 1'b1);
    idle(4);
    n_checks++;
    if (obs_bytes.size() != 1 || rx_byte !== 8'h36) begin
      n_fail++; $display("FAIL glitch_after: got %0d bytes rx_byte=%h want 1 36", obs_bytes.size(), rx_byte);
    end
    pulse_reset();
    idle(4);
  endtask

  task automatic test_reset_mid_line();
    start_test();
    send_byte(8'h39, 1'b1);
    send_byte(8'h2E, 1'b1);
    send_byte(8'h38, 1'b1);
    idle(2);
    pulse_reset();
    n_checks++;
    if ({thousands, hundreds, tens, ones} !== 16'h0000 || rx_byte !== 8'h00) begin
      n_fail++; $display("FAIL midreset_outputs: got digits %h rx_byte %h want 0000 00",
                         {thousands, hundreds, tens, ones}, rx_byte);
    end
    n_checks++;
    if ({data_ready, rx_byte_valid, frame_error, parse_error} !== 4'b0000) begin
      n_fail++; $display("FAIL midreset_pulses: got %b want 0000", {data_ready, rx_byte_valid, frame_error, parse_error});
    end
    idle(4);
    start_test();
    send_line("0.512");
    idle(4);
    n_checks++;
    if (obs_lines.size() != 1 || obs_lines[0] !== 16'h0512) begin
      n_fail++; $display("FAIL midreset_line: got %0d lines, first %h want 1 line 0512",
                         obs_lines.size(), (obs_lines.size() > 0) ? obs_lines[0] : 16'hxxxx);
    end
    n_checks++;
    if ({thousands, hundreds, tens, ones} !== 16'h0512) begin
      n_fail++; $display("FAIL midreset_digits: got %h want 0512", {thousands, hundreds, tens, ones});
    end
  endtask

  task automatic test_pulse_rules();
    n_checks++;
    if (wide_cnt != 0) begin
      n_fail++; $display("FAIL pulse_width: got %0d wide pulses want 0", wide_cnt);
    end
    n_checks++;
    if (clash_cnt != 0) begin
      n_fail++; $display("FAIL pulse_exclusive: got %0d overlaps want 0", clash_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_full_line();
    test_frame_error();
    test_parse_error();
    test_glitch();
    test_reset_mid_line();
    test_pulse_rules();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_receive.md
Name: uart_receive

Overview:
- Serial receiver for the PC link: 8N1 frames, LSB first, idle-high line.
- Parses the 7-character line format "D.DDD" CR LF, which is the same format the board's transmitter emits.
- Delivers four BCD digits with a one-cycle data_ready strobe.
- Sits between the PC serial input pin and the display/BCD consumers; a bench can loop the transmitter's output straight into it.

Parameters:
- OS_RATE, 16, baud_clk cycles per serial bit. Must be even and at least 4.
- SYNC_STAGES, 2, number of input synchronizer flops. Must be at least 2.

Ports:
- baud_clk  input  1  oversample clock, OS_RATE x bit rate
- reset_n  input  1  synchronous active-low reset
- pc_serial_data_in  input  1  asynchronous serial line, idle 1
- thousands  output  4  BCD digit before the decimal point
- hundreds  output  4  first digit after the point
- tens  output  4  second digit after the point
- ones  output  4  third digit after the point
- data_ready  output  1  one-cycle pulse: a new complete line is on the digit outputs
- rx_byte  output  8  last byte received with a good stop bit
- rx_byte_valid  output  1  one-cycle pulse: rx_byte updated
- frame_error  output  1  one-cycle pulse: stop bit sampled 0
- parse_error  output  1  one-cycle pulse: byte did not match the expected character

Behaviour:
- Clock and reset: single clock baud_clk. Reset is synchronous and active-low (reset_n), sampled on posedge baud_clk.
- Reset values:
  - digit outputs, rx_byte: 0
  - all pulse outputs: 0
  - synchronizer flops: 1
  - bit FSM: IDLE; parser index: 0
- Synchronizer: the bit FSM sees only the SYNC_STAGES-flop synchronized line (rxs).
- Bit FSM states: IDLE, START, DATA, STOP. os_cnt counts 0..OS_RATE-1; bit_cnt counts 0..7.
  - IDLE: when rxs==0, go to START with os_cnt=0.
  - START: at os_cnt==OS_RATE/2-1 (mid-bit):
    - rxs==0: go to DATA, os_cnt=0, bit_cnt=0.
    - rxs==1: glitch; return to IDLE with no pulse.
  - DATA: at each os_cnt==OS_RATE-1, shift rxs into shreg[7] with a right shift (LSB first). After bit_cnt==7 is sampled, go to STOP.
  - STOP: at os_cnt==OS_RATE-1, sample rxs:
    - rxs==1: rx_byte<=shreg and rx_byte_valid=1 on the next cycle.
    - rxs==0: frame_error=1; rx_byte unchanged.
    - Either way, return to IDLE.
  - Sampling points are therefore mid-bit for every data bit and the stop bit.
- Receive latency: the rx_byte_valid pulse is roughly 9.5 bit times after the start edge, plus SYNC_STAGES cycles.
- Parser: index 0..6 holds the expected character. It acts only on rx_byte_valid:
  - 0: digit 0x30-0x39, stored as held_thousands = byte[3:0]
  - 1: '.' 0x2E
  - 2: digit, stored to held_hundreds
  - 3: digit, stored to held_tens
  - 4: digit, stored to held_ones
  - 5: CR 0x0D
  - 6: LF 0x0A
- Match: index increments.
  - On a match at index 6: the held values are copied to the digit outputs and data_ready pulses in the same cycle; index returns to 0.
- Mismatch at any index: parse_error pulses for one cycle and index goes to 0. The offending byte is not re-evaluated as a character-0 candidate.
- frame_error: index goes to 0; parse_error is not pulsed.
- Output holding: digit outputs change only on data_ready and hold their last good line otherwise. Partial lines never reach the outputs.
- Start detection after a frame: a start edge arriving during STOP is not detected until IDLE. Minimum tolerated stop length is 1 bit.
- Reset mid-frame or mid-line: the next cycle is in reset state and the partial byte and line are discarded.
- Pulse widths: all pulses are exactly one cycle. data_ready and parse_error are mutually exclusive.

Test Plan:
- Single byte: send 0x35 at OS_RATE=16 with 16 cycles per bit -> rx_byte=0x35, rx_byte_valid pulses once, no errors.
- Full line: "3.141" CR LF -> one data_ready with thousands=3, hundreds=1, tens=4, ones=1; 7 rx_byte_valid pulses.
- Bad stop bit: byte 0x41 with stop=0 -> frame_error pulses once, no rx_byte_valid, rx_byte unchanged. A following clean "1.000" CR LF then gives data_ready with digits 1,0,0,0.
- Parse error: "2,500" CR LF -> parse_error on ',' (index 1), no data_ready, digits still hold the prior line. The next correct line is accepted.
- Start glitch: line low for 4 cycles, then high -> FSM returns to IDLE, no pulses. A following valid byte is received correctly.
- Reset mid-line: assert reset_n=0 for 1 cycle after "9.8" -> all outputs 0. A new full line "0.512" CR LF gives data_ready with digits 0,5,1,2.
